level_sequencer: RTL

Game-flow controller for the car-row datapath. Sequences the game through idle, play, death and level-up phases and drives the per-row traffic configuration (car count, gap, speed, direction) for every car row. Tracks level, lives and score, and pulses re-seed and respawn strobes to the car rows and frog. Sits between the car-row instances (consuming their Car_Collision outputs) and the frog/score display logic. All outputs are frame-rate signals on frame_clk.

---
 rtl/level_sequencer.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/level_sequencer.sv
// Game-flow controller: sequences idle/play/death/level-up phases and
// drives per-row traffic configuration, level, lives and score.

module level_sequencer_row #(
  parameter int ROW = 0
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       i_load,
  input  logic [3:0] i_level,
  output logic [2:0] o_cars,
  output logic [7:0] o_gap,
  output logic [5:0] o_speed,
  output logic       o_dir
);
  localparam logic [7:0] ROW8 = 8'(ROW);

  typedef struct packed {
    logic [2:0] cars;
    logic [7:0] gap;
    logic [5:0] speed;
    logic       dir;
  } cfg_t;

  function automatic cfg_t cfg_of(input logic [3:0] lvl);
    logic [7:0] sum, cars, spd;
    cfg_t c;
    sum  = {4'b0, lvl} + ROW8;
    cars = 8'd1 + (sum >> 1);
    if (cars > 8'd4) cars = 8'd4;
    spd  = ({4'b0, lvl} << 1) + ROW8;
    if (spd > 8'd32) spd = 8'd32;
    c.cars  = cars[2:0];
    c.gap   = 8'd200 - cars * 8'd40;
    c.speed = spd[5:0];
    c.dir   = ROW8[0] ^ lvl[0];
    return c;
  endfunction

  cfg_t r_cfg;

  // Only reloaded on re-seed edges so traffic is constant for the whole level.
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset)       r_cfg <= cfg_of(4'd1);
    else if (i_load) r_cfg <= cfg_of(i_level);
  end

  assign o_cars  = r_cfg.cars;
  assign o_gap   = r_cfg.gap;
  assign o_speed = r_cfg.speed;
  assign o_dir   = r_cfg.dir;
endmodule

module level_sequencer #(
  parameter int NUM_ROWS     = 5,
  parameter int MAX_LEVEL    = 8,
  parameter int START_LIVES  = 3,
  parameter int DEATH_FRAMES = 60
) (
  input  logic                     frame_clk,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [NUM_ROWS-1:0]      Car_Collision,
  input  logic                     Frog_Home,
  output logic [NUM_ROWS-1:0][2:0] Row_Number_Cars,
  output logic [NUM_ROWS-1:0][7:0] Row_Gap_Size,
  output logic [NUM_ROWS-1:0][5:0] Row_Speed,
  output logic [NUM_ROWS-1:0]      Row_Direction,
  output logic                     Row_Reset,
  output logic                     Frog_Respawn,
  output logic [3:0]               Level,
  output logic [2:0]               Lives,
  output logic [15:0]              Score,
  output logic [2:0]               Game_State
);
  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAY      = 3'd1,
    S_DYING     = 3'd2,
    S_LEVEL_UP  = 3'd3,
    S_GAME_OVER = 3'd4
  } state_t;

  localparam logic [3:0] MAXL   = 4'(MAX_LEVEL);
  localparam logic [2:0] LIVES0 = 3'(START_LIVES);
  localparam logic [7:0] TLOAD  = 8'(DEATH_FRAMES - 1);

  state_t      r_state, w_state_nx;
  logic [3:0]  r_level, w_level_nx;
  logic [2:0]  r_lives, w_lives_nx;
  logic [15:0] r_score, w_score_nx;
  logic [7:0]  r_timer, w_timer_nx;
  logic        r_row_reset, w_row_reset_nx;
  logic        r_frog_respawn, w_frog_respawn_nx;

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      r_state        <= S_IDLE;
      r_level        <= 4'd1;
      r_lives        <= LIVES0;
      r_score        <= 16'd0;
      r_timer        <= 8'd0;
      r_row_reset    <= 1'b0;
      r_frog_respawn <= 1'b0;
    end else begin
      r_state        <= w_state_nx;
      r_level        <= w_level_nx;
      r_lives        <= w_lives_nx;
      r_score        <= w_score_nx;
      r_timer        <= w_timer_nx;
      r_row_reset    <= w_row_reset_nx;
      r_frog_respawn <= w_frog_respawn_nx;
    end
  end

  always_comb begin
    w_state_nx        = r_state;
    w_level_nx        = r_level;
    w_lives_nx        = r_lives;
    w_score_nx        = r_score;
    w_timer_nx        = r_timer;
    w_row_reset_nx    = 1'b0;
    w_frog_respawn_nx = 1'b0;
    case (r_state)
      S_IDLE, S_GAME_OVER: begin
        if (Start) begin
          w_state_nx        = S_PLAY;
          w_level_nx        = 4'd1;
          w_lives_nx        = LIVES0;
          w_score_nx        = 16'd0;
          w_row_reset_nx    = 1'b1;
          w_frog_respawn_nx = 1'b1;
        end
      end
      S_PLAY: begin
        if (|Car_Collision) begin
          w_state_nx = S_DYING;
          w_timer_nx = TLOAD;
          if (r_lives != 3'd0) w_lives_nx = r_lives - 3'd1;
        end else if (Frog_Home) begin
          w_state_nx = S_LEVEL_UP;
        end
      end
      S_DYING: begin
        if (r_timer == 8'd0) begin
          if (r_lives == 3'd0) begin
            w_state_nx = S_GAME_OVER;
          end else begin
            w_state_nx        = S_PLAY;
            w_frog_respawn_nx = 1'b1;
          end
        end else begin
          w_timer_nx = r_timer - 8'd1;
        end
      end
      S_LEVEL_UP: begin
        w_state_nx        = S_PLAY;
        w_score_nx        = r_score + 16'd100;
        w_level_nx        = (r_level >= MAXL) ? r_level : r_level + 4'd1;
        w_row_reset_nx    = 1'b1;
        w_frog_respawn_nx = 1'b1;
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_ROWS; g++) begin : g_row
    level_sequencer_row #(.ROW(g)) u_row (
      .frame_clk (frame_clk),
      .Reset     (Reset),
      .i_load    (w_row_reset_nx),
      .i_level   (w_level_nx),
      .o_cars    (Row_Number_Cars[g]),
      .o_gap     (Row_Gap_Size[g]),
      .o_speed   (Row_Speed[g]),
      .o_dir     (Row_Direction[g])
    );
  end

  assign Row_Reset    = r_row_reset;
  assign Frog_Respawn = r_frog_respawn;
  assign Level        = r_level;
  assign Lives        = r_lives;
  assign Score        = r_score;
  assign Game_State   = r_state;
endmodule
